// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: data width, load
// funct3 encodings, the queued load-return entry and load extension.
package wb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_op_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // Pick the byte/half addressed by addr_lo out of the aligned word and
  // sign- or zero-extend it; unknown funct3 values fall back to a full word.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                  input logic [1:0]      addr_lo,
                                                  input logic [XLEN-1:0] word);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      r = {{(XLEN-8){b[7]}}, b};
      LBU:     r = {{(XLEN-8){1'b0}}, b};
      LH:      r = {{(XLEN-16){h[15]}}, h};
      LHU:     r = {{(XLEN-16){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the writeback stage's producer, scoreboard and register-file
// signals. The slave modport is the arbiter; master is its environment.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_stall;

  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;

  logic            iss_load;
  logic [4:0]      iss_rd;
  logic [31:0]     busy;

  logic            we3;
  logic [4:0]      wa3;
  logic [XLEN-1:0] wd3;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_stall,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    output ld_ready,
    input  iss_load, iss_rd,
    output busy,
    output we3, wa3, wd3
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_stall,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    input  ld_ready,
    output iss_load, iss_rd,
    input  busy,
    input  we3, wa3, wd3
  );

endinterface

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO of extended load returns. Pointers carry one extra wrap
// bit so a full FIFO and an empty one are told apart. Push while full and
// pop while empty are ignored.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                head
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          do_push;
  logic          do_pop;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head is read combinationally so the arbiter can write it in the pop cycle.
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  // Entry storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  // Pointer update; reset drops everything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: sole driver of the register-file write port. ALU results
// have priority and land one cycle after presentation; extended load returns
// queue in a FIFO and take free slots, with a starve counter guaranteeing
// the FIFO a slot after MAX_STARVE consecutive ALU wins. Also tracks which
// registers have a load in flight for the decode stall logic.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_STARVE = 4
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_STARVE + 1);

  wb_entry_t       push_entry;
  wb_entry_t       head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;
  logic            push;
  logic            pop;
  logic            alu_win;
  logic            alu_stall;

  logic [CW-1:0]   starve_cnt_reg;
  logic [CW-1:0]   starve_cnt_next;
  logic            we3_reg,  we3_next;
  logic [4:0]      wa3_reg,  wa3_next;
  logic [XLEN-1:0] wd3_reg,  wd3_next;
  logic [31:0]     busy_reg;
  logic [31:0]     busy_next;

  // Loads to x0 are accepted but never queued.
  assign push_entry.rd   = bus.ld_rd;
  assign push_entry.data = load_extend(bus.ld_funct3, bus.ld_addr_lo, bus.ld_data);
  assign push            = bus.ld_valid && !fifo_full && (bus.ld_rd != 5'd0);
  assign bus.ld_ready    = (fifo_count != (AW+1)'(DEPTH));

  wb_load_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head)
  );

  // Arbitration: ALU first unless starving the FIFO; x0 ALU writes yield the slot.
  always_comb begin
    alu_stall       = (starve_cnt_reg == CW'(MAX_STARVE)) && !fifo_empty;
    alu_win         = !alu_stall && bus.alu_valid && (bus.alu_rd != 5'd0);
    pop             = !alu_win && !fifo_empty;
    starve_cnt_next = starve_cnt_reg;
    if (fifo_empty || pop) begin
      starve_cnt_next = '0;
    end else if (alu_win) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
    we3_next = alu_win || pop;
    wa3_next = wa3_reg;
    wd3_next = wd3_reg;
    if (alu_win) begin
      wa3_next = bus.alu_rd;
      wd3_next = bus.alu_data;
    end else if (pop) begin
      wa3_next = head.rd;
      wd3_next = head.data;
    end
  end

  assign bus.alu_stall = alu_stall;

  // Scoreboard: a newly issued load outranks a committing one on the same register.
  assign busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    always_comb begin
      busy_next[gi] = busy_reg[gi];
      if (pop && (head.rd == 5'(gi))) busy_next[gi] = 1'b0;
      if (bus.iss_load && (bus.iss_rd == 5'(gi))) busy_next[gi] = 1'b1;
    end
  end

  // Registered write port, starve counter and scoreboard.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3_reg        <= 1'b0;
      wa3_reg        <= '0;
      wd3_reg        <= '0;
      starve_cnt_reg <= '0;
      busy_reg       <= '0;
    end else begin
      we3_reg        <= we3_next;
      wa3_reg        <= wa3_next;
      wd3_reg        <= wd3_next;
      starve_cnt_reg <= starve_cnt_next;
      busy_reg       <= busy_next;
    end
  end

  assign bus.we3  = we3_reg;
  assign bus.wa3  = wa3_reg;
  assign bus.wd3  = wd3_reg;
  assign bus.busy = busy_reg;

endmodule
